// File: rtl/loop_filter_gain_scheduler_pkg.sv
// Package adpll_ctrl_pkg
// Purpose : shared types and default settings for the ADPLL loop-filter gain
//           scheduler. It provides the gear encoding, the default widths,
//           gains and thresholds, and a helper that sizes counters.
// Ports   : none (package).
package adpll_ctrl_pkg;

  typedef enum logic [1:0] {
    GEAR_IDLE = 2'd0,
    GEAR_ACQ  = 2'd1,
    GEAR_TRK  = 2'd2,
    GEAR_FINE = 2'd3
  } gear_t;

  localparam int unsigned DEF_ERROR_WIDTH   = 8;
  localparam int unsigned DEF_KP_WIDTH      = 5;
  localparam int unsigned DEF_KI_WIDTH      = 11;
  localparam int unsigned DEF_KP_ACQ        = 8;
  localparam int unsigned DEF_KI_ACQ        = 64;
  localparam int unsigned DEF_KP_TRK        = 4;
  localparam int unsigned DEF_KI_TRK        = 8;
  localparam int unsigned DEF_KP_FINE       = 1;
  localparam int unsigned DEF_KI_FINE       = 1;
  localparam int unsigned DEF_LOCK_THRESH   = 2;
  localparam int unsigned DEF_UNLOCK_THRESH = 16;
  localparam int unsigned DEF_LOCK_COUNT    = 8;
  localparam int unsigned DEF_ACQ_TIMEOUT   = 256;

  // Returns the number of bits needed to hold values 0..max_val. The result
  // is never less than 1.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/loop_filter_gain_scheduler_if.sv
// Interface loop_filter_gain_scheduler_if
// Purpose : carries the phase-error stream into the scheduler and carries the
//           gain, gear and lock information back out to the loop filter.
// Signals : error_valid_i/error_i (sample in), kp_o/ki_o (gains out),
//           gear_o, locked_o, int_clear_o (status and integrator clear out).
// Modports: master = phase-detector/filter side, slave = scheduler.
interface loop_filter_gain_scheduler_if
  import adpll_ctrl_pkg::*;
#(
  parameter int unsigned ERROR_WIDTH = DEF_ERROR_WIDTH,
  parameter int unsigned KP_WIDTH    = DEF_KP_WIDTH,
  parameter int unsigned KI_WIDTH    = DEF_KI_WIDTH
);

  logic                          error_valid_i;
  logic signed [ERROR_WIDTH-1:0] error_i;
  logic        [KP_WIDTH-1:0]    kp_o;
  logic        [KI_WIDTH-1:0]    ki_o;
  gear_t                         gear_o;
  logic                          locked_o;
  logic                          int_clear_o;

  modport master (
    output error_valid_i, error_i,
    input  kp_o, ki_o, gear_o, locked_o, int_clear_o
  );

  modport slave (
    input  error_valid_i, error_i,
    output kp_o, ki_o, gear_o, locked_o, int_clear_o
  );

endinterface

// File: rtl/loop_filter_gain_scheduler_lock_detector.sv
// Module lock_detector
// Purpose : computes the error magnitude, counts consecutive good samples
//           (saturating at LOCK_COUNT) and flags the sample that completes
//           a run of good samples, or that breaks lock.
// Ports   : gen_clk_i, reset_i (sync, active high), clear_i (sync counter
//           clear), valid_i/error_i (sample), good_done_o (this valid sample
//           completes LOCK_COUNT good samples), bad_unlock_o (this valid
//           sample has |e| > UNLOCK_THRESH).
module lock_detector
  import adpll_ctrl_pkg::*;
#(
  parameter int unsigned ERROR_WIDTH   = DEF_ERROR_WIDTH,
  parameter int unsigned LOCK_THRESH   = DEF_LOCK_THRESH,
  parameter int unsigned UNLOCK_THRESH = DEF_UNLOCK_THRESH,
  parameter int unsigned LOCK_COUNT    = DEF_LOCK_COUNT
) (
  input  logic                          gen_clk_i,
  input  logic                          reset_i,
  input  logic                          clear_i,
  input  logic                          valid_i,
  input  logic signed [ERROR_WIDTH-1:0] error_i,
  output logic                          good_done_o,
  output logic                          bad_unlock_o
);

  localparam int unsigned MAG_W = ERROR_WIDTH + 1;
  localparam int unsigned CNT_W = cnt_width(LOCK_COUNT);

  logic [MAG_W-1:0] err_ext;
  logic [MAG_W-1:0] mag;
  logic             good;
  logic [CNT_W-1:0] good_cnt;

  // One extra bit so the most negative code negates without wrapping.
  always_comb begin
    err_ext = {error_i[ERROR_WIDTH-1], error_i};
    mag     = error_i[ERROR_WIDTH-1] ? (~err_ext + MAG_W'(1)) : err_ext;
    good    = (mag <= MAG_W'(LOCK_THRESH));
  end

  // The flag fires on the sample that brings the count to LOCK_COUNT, so the
  // gear change lands on that same edge.
  assign good_done_o  = valid_i && good && (good_cnt >= CNT_W'(LOCK_COUNT - 1));
  assign bad_unlock_o = valid_i && (mag > MAG_W'(UNLOCK_THRESH));

  always_ff @(posedge gen_clk_i) begin
    if (reset_i || clear_i) begin
      good_cnt <= '0;
    end else if (valid_i) begin
      if (!good) begin
        good_cnt <= '0;
      end else if (good_cnt < CNT_W'(LOCK_COUNT)) begin
        good_cnt <= good_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/loop_filter_gain_scheduler.sv
// Module loop_filter_gain_scheduler
// Purpose : steps the ADPLL PI loop filter through the IDLE, ACQ, TRK and
//           FINE gears based on the phase-detector error. It drives the
//           kp/ki gains, the lock flag and integrator clear requests. All
//           outputs are registered.
// Ports   : gen_clk_i (clock), reset_i (sync, active high), enable_i (run
//           enable), bus (slave modport: error_valid_i/error_i in,
//           kp_o/ki_o/gear_o/locked_o/int_clear_o out).
module loop_filter_gain_scheduler
  import adpll_ctrl_pkg::*;
#(
  parameter int unsigned ERROR_WIDTH   = DEF_ERROR_WIDTH,
  parameter int unsigned KP_WIDTH      = DEF_KP_WIDTH,
  parameter int unsigned KI_WIDTH      = DEF_KI_WIDTH,
  parameter int unsigned KP_ACQ        = DEF_KP_ACQ,
  parameter int unsigned KI_ACQ        = DEF_KI_ACQ,
  parameter int unsigned KP_TRK        = DEF_KP_TRK,
  parameter int unsigned KI_TRK        = DEF_KI_TRK,
  parameter int unsigned KP_FINE       = DEF_KP_FINE,
  parameter int unsigned KI_FINE       = DEF_KI_FINE,
  parameter int unsigned LOCK_THRESH   = DEF_LOCK_THRESH,
  parameter int unsigned UNLOCK_THRESH = DEF_UNLOCK_THRESH,
  parameter int unsigned LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int unsigned ACQ_TIMEOUT   = DEF_ACQ_TIMEOUT
) (
  input  logic                          gen_clk_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  loop_filter_gain_scheduler_if.slave   bus
);

  localparam int unsigned TCNT_W = cnt_width(ACQ_TIMEOUT);

  gear_t               state;
  logic [KP_WIDTH-1:0] kp_q;
  logic [KI_WIDTH-1:0] ki_q;
  logic                locked_q;
  logic                clr_q;
  logic [TCNT_W-1:0]   tcnt;

  logic good_done;
  logic bad_unlock;
  logic unlock;
  logic advance;
  logic retry;
  logic det_clear;

  // Gear changes are decoded here so that the lock detector's counter
  // clears on the same edge that the FSM moves.
  always_comb begin
    unlock    = ((state == GEAR_TRK) || (state == GEAR_FINE)) && bad_unlock;
    advance   = ((state == GEAR_ACQ) || (state == GEAR_TRK)) && good_done;
    retry     = (state == GEAR_ACQ) && bus.error_valid_i &&
                (tcnt == TCNT_W'(ACQ_TIMEOUT - 1));
    det_clear = !enable_i || (state == GEAR_IDLE) || unlock || advance || retry;
  end

  lock_detector #(
    .ERROR_WIDTH   (ERROR_WIDTH),
    .LOCK_THRESH   (LOCK_THRESH),
    .UNLOCK_THRESH (UNLOCK_THRESH),
    .LOCK_COUNT    (LOCK_COUNT)
  ) u_lock_detector (
    .gen_clk_i    (gen_clk_i),
    .reset_i      (reset_i),
    .clear_i      (det_clear),
    .valid_i      (bus.error_valid_i),
    .error_i      (bus.error_i),
    .good_done_o  (good_done),
    .bad_unlock_o (bad_unlock)
  );

  always_ff @(posedge gen_clk_i) begin
    if (reset_i || !enable_i) begin
      state    <= GEAR_IDLE;
      kp_q     <= '0;
      ki_q     <= '0;
      locked_q <= 1'b0;
      clr_q    <= 1'b1;
      tcnt     <= '0;
    end else begin
      clr_q <= 1'b0;
      unique case (state)
        GEAR_IDLE: begin
          state <= GEAR_ACQ;
          kp_q  <= KP_WIDTH'(KP_ACQ);
          ki_q  <= KI_WIDTH'(KI_ACQ);
          tcnt  <= '0;
        end
        GEAR_ACQ: begin
          if (advance) begin
            state <= GEAR_TRK;
            kp_q  <= KP_WIDTH'(KP_TRK);
            ki_q  <= KI_WIDTH'(KI_TRK);
          end else if (retry) begin
            clr_q <= 1'b1;
            tcnt  <= '0;
          end else if (bus.error_valid_i) begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        GEAR_TRK: begin
          if (unlock) begin
            state <= GEAR_ACQ;
            kp_q  <= KP_WIDTH'(KP_ACQ);
            ki_q  <= KI_WIDTH'(KI_ACQ);
            clr_q <= 1'b1;
            tcnt  <= '0;
          end else if (advance) begin
            state    <= GEAR_FINE;
            kp_q     <= KP_WIDTH'(KP_FINE);
            ki_q     <= KI_WIDTH'(KI_FINE);
            locked_q <= 1'b1;
          end
        end
        GEAR_FINE: begin
          if (unlock) begin
            state    <= GEAR_ACQ;
            kp_q     <= KP_WIDTH'(KP_ACQ);
            ki_q     <= KI_WIDTH'(KI_ACQ);
            locked_q <= 1'b0;
            clr_q    <= 1'b1;
            tcnt     <= '0;
          end
        end
      endcase
    end
  end

  assign bus.kp_o        = kp_q;
  assign bus.ki_o        = ki_q;
  assign bus.gear_o      = state;
  assign bus.locked_o    = locked_q;
  assign bus.int_clear_o = clr_q;

endmodule
